// File: rtl/featuremap_multich_accum.sv
// featuremap_multich_accum: sums NUM_CH skewed per-channel conv result streams
// plus a bias into one fp32 output pixel per handshake. Each channel owns a
// small FIFO; once every FIFO holds a word, one word is popped from each and
// the words are folded into the accumulator through a single shared fp32 adder.
// Optional build macro FEATUREMAP_RELU_EN clamps negative outputs to zero.

// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// NaN and Inf operands pass through unmodified; Inf + -Inf yields a quiet NaN.
module featuremap_fp32_add (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic        swap;
  logic [31:0] x, y, res;
  logic [23:0] sx, sy;
  logic [7:0]  exe, eye, diff, shift;
  logic [50:0] sh;
  logic [26:0] x_al, y_al, n;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [9:0]  e_f, e_out;
  logic        rnd;
  logic [24:0] r;

  // align the smaller operand, add/subtract, normalise, round, then patch specials
  always_comb begin
    swap = (a_i[30:0] < b_i[30:0]);
    x    = swap ? b_i : a_i;
    y    = swap ? a_i : b_i;
    sx   = {|x[30:23], x[22:0]};
    sy   = {|y[30:23], y[22:0]};
    exe  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    eye  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    diff = exe - eye;
    sh   = {sy, 27'd0} >> diff;
    // guard/round bits plus a sticky bit collecting everything shifted out
    if (diff > 8'd26) y_al = {26'd0, |sy};
    else              y_al = {sh[50:25], |sh[24:0]};
    x_al = {sx, 3'b000};
    if (x[31] == y[31]) s = {1'b0, x_al} + {1'b0, y_al};
    else                s = {1'b0, x_al} - {1'b0, y_al};
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end
    // never shift below the minimum exponent: that region becomes subnormal
    shift = ({3'b000, lz} < (exe - 8'd1)) ? {3'b000, lz} : (exe - 8'd1);
    if (s[27]) begin
      n   = {s[27:2], |s[1:0]};
      e_f = {2'b00, exe} + 10'd1;
    end else begin
      n   = s[26:0] << shift;
      e_f = n[26] ? {2'b00, exe - shift} : 10'd0;
    end
    rnd   = n[2] & (n[3] | n[1] | n[0]);
    r     = {1'b0, n[26:3]} + {24'd0, rnd};
    e_out = e_f + {9'd0, r[24]} + {9'd0, (e_f == 10'd0) & r[23]};
    if (s == 28'd0)            res = {x[31] & y[31], 31'd0};
    else if (e_out >= 10'd255) res = {x[31], 8'hFF, 23'd0};
    else                       res = {x[31], e_out[7:0], r[24] ? r[23:1] : r[22:0]};
    if (&a_i[30:23] && |a_i[22:0])      res = a_i;
    else if (&b_i[30:23] && |b_i[22:0]) res = b_i;
    else if (&a_i[30:23] && &b_i[30:23] && (a_i[31] != b_i[31])) res = 32'h7FC00000;
    else if (&a_i[30:23])               res = a_i;
    else if (&b_i[30:23])               res = b_i;
    sum_o = res;
  end
endmodule

module featuremap_multich_accum #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_CH     = 3,
  parameter int                    FIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] BIAS       = 32'h00000000,
  parameter int                    OUT_PIXELS = 1024,
  localparam int                   CW         = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         frame_done,
  output logic [CW-1:0]                pixel_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d, add_sum;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH*DATA_WIDTH-1:0] stage_flat;
  logic                     pop;
  logic                     all_avail;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic [DATA_WIDTH-1:0] stage_q;
      logic [AW:0]           wr_q, rd_q;
      logic                  full_c, push_c;

      // ready depends only on registered pointers, so a full FIFO refuses a
      // push even in a cycle where the FSM pops it
      assign full_c       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      assign empty[gi]    = (wr_q == rd_q);
      assign ch_ready[gi] = ~full_c;
      assign push_c       = ch_valid[gi] & ~full_c;
      assign stage_flat[gi*DATA_WIDTH +: DATA_WIDTH] = stage_q;

      // FIFO pointers; reset empties the FIFO without touching storage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_q <= '0;
          rd_q <= '0;
        end else begin
          if (push_c) wr_q <= wr_q + 1'b1;
          if (pop)    rd_q <= rd_q + 1'b1;
        end
      end

      // FIFO storage write port
      always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_q[AW-1:0]] <= ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end

      // registered read: the popped head word lands in this channel's stage slot
      always_ff @(posedge clk) begin
        if (pop) stage_q <= mem_q[rd_q[AW-1:0]];
      end
    end
  endgenerate

  assign all_avail = &(~empty);

  featuremap_fp32_add u_add (
    .a_i   (acc_q),
    .b_i   (stage_flat[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH]),
    .sum_o (add_sum)
  );

  // next-state, pop and frame-pulse decode
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (all_avail) begin
          pop     = 1'b1;
          acc_d   = BIAS;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = add_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_CH - 1)) state_d = OUT;
      end
      OUT: begin
        if (ready_in) begin
          if (cnt_q == CW'(OUT_PIXELS - 1)) begin
            cnt_d      = '0;
            frame_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // chain straight into the next pixel when every channel is ready
          if (all_avail) begin
            pop     = 1'b1;
            acc_d   = BIAS;
            idx_d   = '0;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset drops any partial sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out = (state_q == OUT);
  assign pixel_cnt = cnt_q;

`ifdef FEATUREMAP_RELU_EN
  // ReLU on the output path only; the accumulator keeps the signed value
  assign data_out = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
  assign data_out = acc_q;
`endif

endmodule

// File: tb/tb_featuremap_multich_accum.sv
// Directed bench for featuremap_multich_accum (NUM_CH=3, FIFO_DEPTH=4,
// BIAS=1.0, OUT_PIXELS=4). Expected pixels go into a scoreboard queue as the
// stimulus is driven and are popped by a monitor on each output handshake.
`timescale 1ns/1ps
module tb_featuremap_multich_accum;
  localparam int NCH = 3;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0]    ch_valid = '0;
  logic [NCH-1:0]    ch_ready;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic              ready_in = 1'b0;
  logic              frame_done;
  logic [1:0]        pixel_cnt;

  int compared   = 0;
  int mismatched = 0;
  int mcnt       = 0;
  int fd_seen    = 0;
  int hs_total   = 0;
  logic [31:0] sb[$];

  // eight-pixel stream: channel words and bias(1.0)+sum results
  logic [31:0] t5_c0 [8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
                             32'h40400000, 32'h00000000, 32'h3F800000, 32'hC0000000};
  logic [31:0] t5_c1 [8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
                             32'h40400000, 32'h00000000, 32'h40000000, 32'h3F800000};
  logic [31:0] t5_c2 [8] = '{32'h3F800000, 32'h40000000, 32'h00000000, 32'hBF800000,
                             32'h40400000, 32'h00000000, 32'h40400000, 32'h3F000000};
  logic [31:0] t5_ex [8] = '{32'h40800000, 32'h40E00000, 32'h40000000, 32'hC0000000,
                             32'h41200000, 32'h3F800000, 32'h40E00000, 32'h3F000000};

  featuremap_multich_accum #(
    .DATA_WIDTH (32),
    .NUM_CH     (3),
    .FIFO_DEPTH (4),
    .BIAS       (32'h3F800000),
    .OUT_PIXELS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .frame_done (frame_done),
    .pixel_cnt  (pixel_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] post(input logic [31:0] v);
`ifdef FEATUREMAP_RELU_EN
    return v[31] ? 32'h00000000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2);
    int n = 0;
    while (((ch_ready & mask) != mask) && n < 200) begin
      tick();
      n++;
    end
    compared++;
    assert (n < 200) else begin
      mismatched++;
      $error("FAIL push_timeout: observed ready %b expected %b", ch_ready, mask);
    end
    ch_data  = {d2, d1, d0};
    ch_valid = mask;
    tick();
    ch_valid = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || valid_out) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // output monitor: scoreboard pop, pixel counter and frame pulse model
  always @(negedge clk) begin
    if (!rst) begin
      mcnt = 0;
    end else if (valid_out && ready_in) begin
      logic [31:0] exp_v;
      hs_total++;
      chk("pixel_cnt", 32'(pixel_cnt), 32'(mcnt));
      chk("frame_done_hs", 32'(frame_done), 32'(mcnt == 3));
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_output: observed %h expected no pixel", data_out);
      end
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        chk("data_out", data_out, exp_v);
      end
      if (frame_done) fd_seen++;
      $display("pixel %0d: data_out=%h pixel_cnt=%0d frame_done=%0b", hs_total, data_out,
               pixel_cnt, frame_done);
      mcnt = (mcnt + 1) % 4;
    end else begin
      chk("frame_done_idle", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fd_before;
    logic [31:0] held;

    // reset state
    repeat (3) tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pixel_cnt", 32'(pixel_cnt), 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'd7);
    rst = 1'b1;
    tick();

    // 1.0 + 1 + 2 + 3 = 7.0, valid after NUM_CH+1 edges from the push edge
    ready_in = 1'b0;
    push(3'b111, 32'h3F800000, 32'h40000000, 32'h40400000);
    sb.push_back(post(32'h40E00000));
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) chk("t1_valid_early", 32'(valid_out), 32'd0);
    end
    chk("t1_valid", 32'(valid_out), 32'd1);
    chk("t1_data", data_out, post(32'h40E00000));
    ready_in = 1'b1;
    drain();

    // 1.0 - 1 - 2 - 3 = -5.0
    push(3'b111, 32'hBF800000, 32'hC0000000, 32'hC0400000);
    sb.push_back(post(32'hC0A00000));
    drain();

    // fill ch0 alone: ready drops after the 4th word and the 5th is refused
    push(3'b001, 32'h3F800000, 32'h0, 32'h0);
    push(3'b001, 32'h40000000, 32'h0, 32'h0);
    push(3'b001, 32'h40400000, 32'h0, 32'h0);
    push(3'b001, 32'h40800000, 32'h0, 32'h0);
    chk("t3_full", 32'(ch_ready[0]), 32'd0);
    ch_data  = {32'h0, 32'h0, 32'h40A00000};
    ch_valid = 3'b001;
    tick();
    ch_valid = '0;
    chk("t3_still_full", 32'(ch_ready[0]), 32'd0);
    repeat (5) tick();
    chk("t3_idle", 32'(valid_out), 32'd0);
    push(3'b110, 32'h0, 32'h40000000, 32'h3F000000);
    sb.push_back(post(32'h40900000));
    drain();
    chk("t3_ready_back", 32'(ch_ready[0]), 32'd1);

    // backpressure hold, then OUT chains directly into ACC
    ready_in = 1'b0;
    push(3'b110, 32'h0, 32'h3F800000, 32'h3F800000);
    sb.push_back(post(32'h40A00000));
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    chk("t4_valid", 32'(valid_out), 32'd1);
    chk("t4_data", data_out, post(32'h40A00000));
    held = data_out;
    push(3'b110, 32'h0, 32'h40000000, 32'h40000000);
    sb.push_back(post(32'h41000000));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", 32'(valid_out), 32'd1);
      chk("t4_hold_data", data_out, held);
    end
    ready_in = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_out && n < 20);
    chk("t4_out_to_acc_edges", 32'(n), 32'd4);
    drain();

    // reset clears the leftover ch0 word and the pixel counter
    rst = 1'b0;
    #1;
    chk("rsta_ready", 32'(ch_ready), 32'd7);
    chk("rsta_pixel_cnt", 32'(pixel_cnt), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // eight-pixel stream across two frames of four
    fd_before = fd_seen;
    for (int k = 0; k < 8; k++) begin
      push(3'b111, t5_c0[k], t5_c1[k], t5_c2[k]);
      sb.push_back(post(t5_ex[k]));
    end
    drain();
    chk("t5_frame_pulses", 32'(fd_seen - fd_before), 32'd2);
    chk("t5_pixel_cnt_wrap", 32'(pixel_cnt), 32'd0);

    // reset during ACC with two words queued per channel
    push(3'b111, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    push(3'b111, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    push(3'b111, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(valid_out), 32'd0);
    chk("t6_data", data_out, 32'd0);
    chk("t6_ready", 32'(ch_ready), 32'd7);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t6_no_output", 32'(valid_out), 32'd0);
    end
    push(3'b111, 32'h40400000, 32'h40400000, 32'h40400000);
    sb.push_back(post(32'h41200000));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
